// File: rtl/minilab_pkg.sv
// +----------------------------------------------------------------------------+
// | minilab_pkg                                                                |
// | Shared types and sizes for the matrix-vector engine fill path.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package minilab_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int ELEM_W      = 8;
  localparam int MEM_W       = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    PUSH = 3'd3,
    DONE = 3'd4
  } loader_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_fifo_loader_word_serializer.sv
// +----------------------------------------------------------------------------+
// | word_serializer                                                            |
// | Holds one memory word and emits its elements LSB first, one per accepted   |
// | handshake; last marks the final element of the word.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module word_serializer
  import minilab_pkg::*;
#(
  parameter int MEM_WIDTH  = MEM_W,
  parameter int DATA_WIDTH = ELEM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [MEM_WIDTH-1:0]  word,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  fire,
  output logic                  last
);

  localparam int ELEMS = MEM_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;

  logic [MEM_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_valid;

  assign valid = r_valid;
  assign fire  = r_valid & ready;
  assign last  = (r_idx == IDX_W'(ELEMS - 1));
  assign data  = r_word[r_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_word  <= word;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (fire) begin
      // A blocked element keeps its index until the consumer has room.
      if (last) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_fifo_loader.sv
// +----------------------------------------------------------------------------+
// | matrix_fifo_loader                                                         |
// | Reads B and the A rows from memory and fans their bytes into the input     |
// | FIFOs. Optional: MINILAB_LOADER_STALL_CNT_EN adds the stall_cycles count.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module matrix_fifo_loader
  import minilab_pkg::*;
#(
  parameter int                    NUM_ROWS   = MATRIX_ROWS,
  parameter int                    DATA_WIDTH = ELEM_W,
  parameter int                    MEM_WIDTH  = MEM_W,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
`ifdef MINILAB_LOADER_STALL_CNT_EN
  output logic [15:0]           stall_cycles,
`endif
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [MEM_WIDTH-1:0]  avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_WIDTH-1:0] fifo_wrdata,
  output logic [NUM_ROWS:0]     fifo_wrreq,
  input  logic [NUM_ROWS:0]     fifo_wrfull
);

  localparam int LINES  = NUM_ROWS + 1;
  localparam int LINE_W = $clog2(LINES);

  loader_state_t         r_state;
  logic [LINE_W-1:0]     r_line;
  logic [LINE_W-1:0]     w_next_line;
  logic                  w_load;
  logic                  w_ready;
  logic                  w_ser_valid;
  logic                  w_fire;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_byte;

  assign w_next_line = r_line + 1'b1;
  assign w_load      = (r_state == WAIT) && avm_readdatavalid;
  assign w_ready     = ~fifo_wrfull[r_line];

  word_serializer #(
    .MEM_WIDTH  (MEM_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .word  (avm_readdata),
    .ready (w_ready),
    .data  (w_byte),
    .valid (w_ser_valid),
    .fire  (w_fire),
    .last  (w_last)
  );

  // Push strobe must track wrfull in the same cycle, so it is decoded, not registered.
  assign fifo_wrreq  = (w_fire && r_state == PUSH) ? (LINES'(1) << r_line) : '0;
  assign fifo_wrdata = w_ser_valid ? w_byte : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_line      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state     <= REQ;
            r_line      <= '0;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= BASE_ADDR;
          end
        end
        REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (avm_readdatavalid) r_state <= PUSH;
        end
        PUSH: begin
          if (w_fire && w_last) begin
            if (r_line == LINE_W'(NUM_ROWS)) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_line      <= w_next_line;
              r_state     <= REQ;
              avm_read    <= 1'b1;
              avm_address <= BASE_ADDR + ADDR_WIDTH'(w_next_line);
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MINILAB_LOADER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (r_state == IDLE && start) begin
      stall_cycles <= '0;
    end else if ((r_state == REQ && avm_waitrequest) ||
                 (r_state == PUSH && w_ser_valid && !w_ready)) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_fifo_loader.sv
// +----------------------------------------------------------------------------+
// | tb_matrix_fifo_loader                                                      |
// | Scoreboard bench: memory model queues expected pushes as data is returned. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_matrix_fifo_loader;

  localparam int LINES = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [7:0]  fifo_wrdata;
  logic [8:0]  fifo_wrreq;
  logic [8:0]  fifo_wrfull;
`ifdef MINILAB_LOADER_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  matrix_fifo_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
`ifdef MINILAB_LOADER_STALL_CNT_EN
    .stall_cycles      (stall_cycles),
`endif
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .fifo_wrdata       (fifo_wrdata),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_wrfull       (fifo_wrfull)
  );

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int busy_start_cyc, spur_cyc, full_row, full_from, full_len;
  int stall_addr, stall_len, abort_cyc;
  bit timing_chk, byte_pattern;

  int done_cyc;
  bit busy_ok;
  int accepts[LINES];
  int pushes[LINES];

  function automatic logic [63:0] mem_word(input int a);
    logic [7:0] b;
    b = a[7:0];
    if (byte_pattern && a == 0) return 64'h0807060504030201;
    return {8{b}};
  endfunction

  task automatic clear_cfg();
    busy_start_cyc = -1; spur_cyc = -1; full_row = 0; full_from = -1; full_len = 0;
    stall_addr = -1; stall_len = 0; abort_cyc = -1;
    timing_chk = 1'b1; byte_pattern = 1'b0;
  endtask

  // Drives one load from start to done; cycle n is the cycle after edge n-1, start at edge 0.
  task automatic run_load(input int budget);
    int   exp_line, stall_left, pend_addr, idx;
    bit   pending, stall_act;
    exp_t e;
    exp_line = 0; stall_left = stall_len; pending = 0; stall_act = 0; pend_addr = 0;
    done_cyc = -1; busy_ok = 1'b1;
    sb.delete();
    for (int i = 0; i < LINES; i++) begin accepts[i] = 0; pushes[i] = 0; end
    @(negedge clk);
    start = 1'b1;
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      start = (rel == busy_start_cyc);
      fifo_wrfull = (full_len > 0 && rel >= full_from && rel < full_from + full_len) ?
                    (9'd1 << full_row) : 9'd0;
      if (pending) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(pend_addr);
        for (int i = 0; i < 8; i++) begin
          e.idx = pend_addr; e.data = avm_readdata[i*8 +: 8];
          e.cyc = timing_chk ? rel + 1 + i : -1;
          sb.push_back(e);
        end
        pending = 1'b0;
      end else if (rel == spur_cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 64'hA5A5_5A5A_DEAD_BEEF;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end
      if (stall_act || (stall_left > 0 && avm_read && avm_address == 32'(stall_addr))) begin
        stall_act = 1'b1;
        avm_waitrequest = 1'b1;
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 32'(stall_addr)) begin
          errors++;
          $display("FAIL stall_hold cycle %0d: read=%b addr=%0d, required read=1 addr=%0d",
                   rel, avm_read, avm_address, stall_addr);
        end
        stall_left--;
        if (stall_left == 0) stall_act = 1'b0;
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (rel == abort_cyc) begin
        rst = 1'b1;
        sb.delete();
        return;
      end
      #1;
      if (avm_read && !avm_waitrequest) begin
        checks++;
        if (avm_address !== 32'(exp_line)) begin
          errors++;
          $display("FAIL read_addr cycle %0d: got %0d, required %0d", rel, avm_address, exp_line);
        end
        if (avm_address < LINES) accepts[avm_address]++;
        pending   = 1'b1;
        pend_addr = int'(avm_address);
        exp_line++;
      end
      if (fifo_wrreq != 9'd0) begin
        checks++;
        if (!$onehot(fifo_wrreq) || (fifo_wrreq & fifo_wrfull) != 9'd0) begin
          errors++;
          $display("FAIL wrreq_legal cycle %0d: wrreq=%b wrfull=%b, required one-hot and not full",
                   rel, fifo_wrreq, fifo_wrfull);
        end
        idx = $clog2(fifo_wrreq);
        if (idx < LINES) pushes[idx]++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL push_extra cycle %0d: fifo %0d data %h, required no push", rel, idx, fifo_wrdata);
        end else begin
          e = sb.pop_front();
          if (idx !== e.idx || fifo_wrdata !== e.data || (e.cyc >= 0 && rel != e.cyc)) begin
            errors++;
            $display("FAIL push cycle %0d: fifo %0d data %h, required fifo %0d data %h cycle %0d",
                     rel, idx, fifo_wrdata, e.idx, e.data, e.cyc);
          end
        end
      end
      if (done) begin
        done_cyc = rel;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %b, required 0", busy);
        end
        break;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    start = 1'b0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0; fifo_wrfull = '0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending bytes, required 0", sb.size());
    end
  endtask

  task automatic check_done_busy(input string name, input int exp_done);
    checks++;
    if (done_cyc != exp_done || !busy_ok) begin
      errors++;
      $display("FAIL %s_timing: done cycle %0d busy_ok %b, required done cycle %0d busy_ok 1",
               name, done_cyc, busy_ok, exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
    avm_readdatavalid = 1'b0; fifo_wrfull = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, avm_read, avm_address, fifo_wrreq, fifo_wrdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b read=%b addr=%h wrreq=%b wrdata=%h, required all 0",
               busy, done, avm_read, avm_address, fifo_wrreq, fifo_wrdata);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_cfg();
    run_load(200);
    check_done_busy("basic", 91);
    for (int r = 0; r < LINES; r++) begin
      checks++;
      if (pushes[r] != 8 || accepts[r] != 1) begin
        errors++;
        $display("FAIL basic_count fifo %0d: pushes %0d reads %0d, required 8 and 1", r, pushes[r], accepts[r]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b after done, required 0 0", done, busy);
    end
  endtask

  task automatic test_byte_order();
    clear_cfg();
    byte_pattern = 1'b1;
    run_load(200);
    check_done_busy("byte_order", 91);
  endtask

  task automatic test_waitrequest();
    clear_cfg();
    stall_addr = 3; stall_len = 5;
    run_load(200);
    check_done_busy("waitrequest", 96);
    checks++;
    if (accepts[3] != 1) begin
      errors++;
      $display("FAIL stall_accepts: got %0d reads of addr 3, required 1", accepts[3]);
    end
`ifdef MINILAB_LOADER_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 16'd5) begin
      errors++;
      $display("FAIL stall_cnt_req: got %0d, required 5", stall_cycles);
    end
`endif
  endtask

  task automatic test_wrfull();
    clear_cfg();
    timing_chk = 1'b0; full_row = 2; full_from = 25; full_len = 4;
    run_load(200);
    check_done_busy("wrfull", 95);
    checks++;
    if (pushes[2] != 8) begin
      errors++;
      $display("FAIL wrfull_pushes: got %0d pushes to fifo 2, required 8", pushes[2]);
    end
`ifdef MINILAB_LOADER_STALL_CNT_EN
    checks++;
    if (stall_cycles !== 16'd4) begin
      errors++;
      $display("FAIL stall_cnt_full: got %0d, required 4", stall_cycles);
    end
`endif
  endtask

  task automatic test_reset_mid_load();
    clear_cfg();
    abort_cyc = 45;
    run_load(200);
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, avm_read, avm_address, fifo_wrreq, fifo_wrdata} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b read=%b addr=%h wrreq=%b wrdata=%h, required all 0",
               busy, done, avm_read, avm_address, fifo_wrreq, fifo_wrdata);
    end
    @(negedge clk);
    rst = 1'b0;
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    clear_cfg();
    run_load(200);
    check_done_busy("reload", 91);
  endtask

  task automatic test_spurious();
    clear_cfg();
    busy_start_cyc = 30; spur_cyc = 35;
    run_load(200);
    check_done_busy("spurious", 91);
    for (int r = 0; r < LINES; r++) begin
      checks++;
      if (pushes[r] != 8 || accepts[r] != 1) begin
        errors++;
        $display("FAIL spurious_count fifo %0d: pushes %0d reads %0d, required 8 and 1", r, pushes[r], accepts[r]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_order();
    test_waitrequest();
    test_wrfull();
    test_reset_mid_load();
    test_spurious();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
